mem_controller_burst: RTL and testbench
=======================================

Name: mem_controller_burst

Overview:
Packet-driven memory controller between the UART RX/TX FIFOs and an internal word-addressed synchronous memory.
It parses byte packets from the RX FIFO and supports single and burst reads and writes.
Words are wider than one byte and the address spans multiple bytes.
Read data is streamed back byte-serially to the TX FIFO under backpressure.

Parameters:
FIFO_WIDTH, 8, width of FIFO bytes (din/dout).
MEM_WIDTH, 32, memory word width; multiple of FIFO_WIDTH; NUM_BYTES = MEM_WIDTH/FIFO_WIDTH.
MEM_DEPTH, 1024, number of words; power of two; AW = $clog2(MEM_DEPTH).
ADDR_BYTES, 2, address bytes per packet; ADDR_BYTES*FIFO_WIDTH >= AW.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_fifo_empty  in  1  RX FIFO has no data
tx_fifo_full  in  1  TX FIFO cannot accept data
din  in  FIFO_WIDTH  RX FIFO read data, valid the cycle after rx_fifo_rd_en
rx_fifo_rd_en  out  1  pop one RX byte
tx_fifo_wr_en  out  1  push dout into TX FIFO
dout  out  FIFO_WIDTH  TX byte
state_leds  out  6  status: [2:0] state code, [3] write packet active, [4] read packet active, [5] sticky bad-command flag

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, on clk and rst.
- Reset effects:
  - State goes to IDLE; all counters, fetch flag and state_leds[5] clear.
  - rx_fifo_rd_en, tx_fifo_wr_en and dout are 0 in the reset cycle and the cycle after.
  - Memory contents are not cleared.
  - Reset mid-packet abandons the packet; remaining RX bytes are parsed as a new packet.
- Packet format (all fields MSB-first):
  - CMD byte.
  - ADDR_BYTES address bytes; only the low AW bits are used.
  - LEN byte; word count = LEN+1, range 1..256.
  - Write packets only: (LEN+1)*NUM_BYTES data bytes, each word MSB byte first.
- Commands: 0x30 = read, 0x31 = write. Any other CMD sets state_leds[5], is dropped, and returns the block to IDLE with no memory access and no TX output.
- Byte fetch rule:
  - rx_fifo_rd_en is asserted for one cycle only in a fetch state, when !rx_fifo_empty and no fetch is outstanding.
  - din is captured on the following cycle.
  - rd_en is never asserted on two consecutive cycles; peak throughput is 1 byte per 2 cycles.
  - Empty stalls are indefinite, with no timeout.
- State codes: IDLE=0, READ_CMD=1, READ_ADDR=2, READ_LEN=3, READ_DATA=4, WRITE_MEM=5, READ_MEM=6, ECHO=7.
- Transitions:
  - IDLE -> READ_CMD when !rx_fifo_empty.
  - READ_CMD -> READ_ADDR on a valid CMD; -> IDLE on a bad CMD.
  - READ_ADDR -> READ_LEN after ADDR_BYTES captured bytes.
  - READ_LEN -> READ_DATA (write) or READ_MEM (read).
  - READ_DATA shifts bytes into the word register; -> WRITE_MEM after NUM_BYTES bytes.
  - WRITE_MEM drives we = all ones for exactly 1 cycle at the current address, then increments the address. Next state is READ_DATA if words remain, else IDLE.
  - READ_MEM drives the address with we=0 for 1 cycle. mem_dout is latched into the shift register on the next cycle, entering ECHO.
  - ECHO: while !tx_fifo_full, asserts tx_fifo_wr_en with dout = next byte (MSB first), one byte per cycle. When tx_fifo_full is high, wr_en=0 and the byte is held.
  - After the last byte of a word, the address increments. Next state is READ_MEM if words remain, else IDLE.
- Address arithmetic: increment modulo MEM_DEPTH, so a burst starting at MEM_DEPTH-1 wraps to 0.
- Remaining-word counter: 9 bits, loaded with LEN+1.
- dout holds its last value when wr_en=0.
- state_leds[3] is high from a valid write CMD until return to IDLE; state_leds[4] likewise for read.
- No simultaneous RX pop and TX push is required, since reads pop nothing after LEN.
- Implementation: 2-always FSM (state register plus combinational next-state/outputs) with registered datapath counters.

Test Plan:
1. Single write then read: RX 31 00 05 00 DE AD BE EF, then 30 00 05 00 -> exactly 4 tx_fifo_wr_en pulses with dout DE, AD, BE, EF; mem[5]=0xDEADBEEF.
2. Burst wrap: write 31 03 FF 02 followed by 12 bytes 00..0B -> mem[0x3FF]=0x00010203, mem[0x000]=0x04050607, mem[0x001]=0x08090A0B. Read 30 03 FF 02 returns the same 12 bytes in order.
3. TX backpressure: during the read in scenario 2, hold tx_fifo_full high for 10 cycles after the 2nd byte -> no wr_en while full, byte 3 (02) emitted first after release, 12 bytes total with none lost or duplicated.
4. RX starvation: feed scenario 1's write bytes with random 0-20 cycle empty gaps -> rd_en never pulses while empty or on consecutive cycles; memory result is identical.
5. Bad command: RX 7A, then scenario 1's read packet -> state_leds[5]=1, 7A yields no memory access and no TX byte; the read still returns DE AD BE EF.
6. Reset mid-burst: assert rst for 1 cycle after 6 data bytes of a 3-word write -> state_leds=0. Only the first word is written; a subsequent fresh packet is handled correctly.

Source files
------------

// File: rtl/mem_controller_burst_if.sv
// FIFO-side bus of the packet memory controller: RX pop, TX push and status LEDs.
interface mem_controller_burst_if #(
    parameter int FIFO_WIDTH = 8
);
    logic                  rx_fifo_empty;
    logic                  tx_fifo_full;
    logic [FIFO_WIDTH-1:0] din;
    logic                  rx_fifo_rd_en;
    logic                  tx_fifo_wr_en;
    logic [FIFO_WIDTH-1:0] dout;
    logic [5:0]            state_leds;

    modport master (
        input  rx_fifo_empty, tx_fifo_full, din,
        output rx_fifo_rd_en, tx_fifo_wr_en, dout, state_leds
    );

    modport slave (
        output rx_fifo_empty, tx_fifo_full, din,
        input  rx_fifo_rd_en, tx_fifo_wr_en, dout, state_leds
    );
endinterface

// File: rtl/mem_controller_burst.sv
// Packet-driven burst memory controller: parses CMD/ADDR/LEN/DATA bytes from the RX FIFO,
// writes words into an internal synchronous RAM, and streams read words byte-serially to TX.
module mem_controller_burst #(
    parameter int FIFO_WIDTH = 8,
    parameter int MEM_WIDTH  = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_BYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_controller_burst_if.master bus
);
    localparam int NUM_BYTES = MEM_WIDTH / FIFO_WIDTH;
    localparam int AW        = $clog2(MEM_DEPTH);
    localparam int CNT_MAX   = (ADDR_BYTES > NUM_BYTES) ? ADDR_BYTES : NUM_BYTES;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int LW        = FIFO_WIDTH + 1;

    localparam logic [FIFO_WIDTH-1:0] CMD_READ  = FIFO_WIDTH'(8'h30);
    localparam logic [FIFO_WIDTH-1:0] CMD_WRITE = FIFO_WIDTH'(8'h31);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ_CMD  = 3'd1,
        READ_ADDR = 3'd2,
        READ_LEN  = 3'd3,
        READ_DATA = 3'd4,
        WRITE_MEM = 3'd5,
        READ_MEM  = 3'd6,
        ECHO      = 3'd7
    } state_t;

    state_t                  state, state_next;
    logic                    fetch_pending;
    logic [CW-1:0]           byte_cnt;
    logic [AW-1:0]           addr;
    logic [AW-1:0]           addr_shifted;
    logic [LW-1:0]           words_left;
    logic [MEM_WIDTH-1:0]    word_reg;
    logic [MEM_WIDTH-1:0]    word_shifted;
    logic [MEM_WIDTH-1:0]    mem_dout;
    logic                    is_write, is_read, bad_cmd;
    logic [FIFO_WIDTH-1:0]   dout_hold;
    logic [FIFO_WIDTH-1:0]   tx_byte;
    logic                    rd_en, wr_en, mem_we, mem_re;
    logic                    last_addr_byte, last_word_byte, last_word;

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    // Address and data bytes arrive MSB first; keep only the low bits that fit.
    generate
        if (AW > FIFO_WIDTH) begin : g_addr_wide
            assign addr_shifted = {addr[AW-FIFO_WIDTH-1:0], bus.din};
        end else begin : g_addr_narrow
            assign addr_shifted = bus.din[AW-1:0];
        end
        if (NUM_BYTES > 1) begin : g_word_wide
            assign word_shifted = {word_reg[MEM_WIDTH-FIFO_WIDTH-1:0], bus.din};
        end else begin : g_word_narrow
            assign word_shifted = bus.din;
        end
    endgenerate

    assign last_addr_byte = (byte_cnt == CW'(ADDR_BYTES - 1));
    assign last_word_byte = (byte_cnt == CW'(NUM_BYTES - 1));
    assign last_word      = (words_left == LW'(1));
    assign tx_byte        = mem_dout[(NUM_BYTES - 1 - int'(byte_cnt)) * FIFO_WIDTH +: FIFO_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        // A pop is only issued when the previous one has been captured.
        if (state inside {READ_CMD, READ_ADDR, READ_LEN, READ_DATA})
            rd_en = !bus.rx_fifo_empty && !fetch_pending && !rst;
        case (state)
            IDLE:      if (!bus.rx_fifo_empty) state_next = READ_CMD;
            READ_CMD:  if (fetch_pending)
                           state_next = (bus.din == CMD_READ || bus.din == CMD_WRITE) ? READ_ADDR : IDLE;
            READ_ADDR: if (fetch_pending && last_addr_byte) state_next = READ_LEN;
            READ_LEN:  if (fetch_pending) state_next = is_write ? READ_DATA : READ_MEM;
            READ_DATA: if (fetch_pending && last_word_byte) state_next = WRITE_MEM;
            WRITE_MEM: begin
                mem_we     = !rst;
                state_next = last_word ? IDLE : READ_DATA;
            end
            READ_MEM: begin
                mem_re     = 1'b1;
                state_next = ECHO;
            end
            ECHO: if (!bus.tx_fifo_full) begin
                wr_en = !rst;
                if (last_word_byte) state_next = last_word ? IDLE : READ_MEM;
            end
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pending <= 1'b0;
            byte_cnt      <= '0;
            addr          <= '0;
            words_left    <= '0;
            word_reg      <= '0;
            is_write      <= 1'b0;
            is_read       <= 1'b0;
            bad_cmd       <= 1'b0;
            dout_hold     <= '0;
        end else begin
            fetch_pending <= rd_en;
            if (wr_en) dout_hold <= tx_byte;
            case (state)
                READ_CMD: if (fetch_pending) begin
                    if (bus.din == CMD_READ)       is_read  <= 1'b1;
                    else if (bus.din == CMD_WRITE) is_write <= 1'b1;
                    else                           bad_cmd  <= 1'b1;
                end
                READ_ADDR: if (fetch_pending) begin
                    addr     <= addr_shifted;
                    byte_cnt <= last_addr_byte ? '0 : byte_cnt + CW'(1);
                end
                READ_LEN: if (fetch_pending) words_left <= LW'(bus.din) + LW'(1);
                READ_DATA: if (fetch_pending) begin
                    word_reg <= word_shifted;
                    byte_cnt <= last_word_byte ? '0 : byte_cnt + CW'(1);
                end
                WRITE_MEM: begin
                    addr       <= addr + AW'(1);
                    words_left <= words_left - LW'(1);
                end
                ECHO: if (wr_en) begin
                    if (last_word_byte) begin
                        byte_cnt   <= '0;
                        addr       <= addr + AW'(1);
                        words_left <= words_left - LW'(1);
                    end else begin
                        byte_cnt <= byte_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
            if (state_next == IDLE) begin
                is_write <= 1'b0;
                is_read  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= word_reg;
        if (mem_re) mem_dout <= mem[addr];
    end

    assign bus.rx_fifo_rd_en = rd_en;
    assign bus.tx_fifo_wr_en = wr_en;
    assign bus.dout          = rst ? '0 : (wr_en ? tx_byte : dout_hold);
    assign bus.state_leds    = {bad_cmd, is_read, is_write, state};
endmodule

// File: tb/tb_mem_controller_burst.sv
// Randomised self-checking bench: RX/TX FIFO models driven from queues, a word-array reference
// memory, and directed scenarios for wrap, backpressure, starvation, bad command and reset.
module tb_mem_controller_burst;
    localparam int FW    = 8;
    localparam int MW    = 32;
    localparam int DEPTH = 1024;
    localparam int AB    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_controller_burst_if #(.FIFO_WIDTH(FW)) bus ();

    mem_controller_burst #(
        .FIFO_WIDTH(FW),
        .MEM_WIDTH(MW),
        .MEM_DEPTH(DEPTH),
        .ADDR_BYTES(AB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_got[$];
    logic [7:0]  tx_exp[$];
    logic [31:0] wq[$];
    logic [31:0] ref_mem [DEPTH];

    int starve_max  = 0;
    int starve_left = 0;
    int bp_trigger  = -1;
    int bp_left     = 0;
    bit rand_bp     = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RX FIFO: pops on rd_en, presents the byte the following cycle, optional empty gaps.
    initial begin : rx_proc
        bit pop;
        bit prev_rd;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            pop = 1'b0;
            if (bus.rx_fifo_rd_en === 1'b1) begin
                check_eq("rd_en_while_empty", 64'(bus.rx_fifo_empty), 64'd0);
                check_eq("rd_en_back_to_back", 64'(prev_rd), 64'd0);
                pop = 1'b1;
            end
            prev_rd = (bus.rx_fifo_rd_en === 1'b1);
            @(posedge clk);
            #1;
            if (pop && rx_q.size() > 0) begin
                bus.din = rx_q.pop_front();
                if (starve_max > 0) starve_left = $urandom_range(0, starve_max);
            end else if (starve_left > 0) begin
                starve_left--;
            end
            bus.rx_fifo_empty = (rx_q.size() == 0) || (starve_left > 0);
        end
    end

    // TX FIFO: records pushed bytes; full is forced after a chosen byte or toggled randomly.
    initial begin : tx_proc
        forever begin
            @(negedge clk);
            if (bus.tx_fifo_wr_en === 1'b1) begin
                check_eq("wr_en_while_full", 64'(bus.tx_fifo_full), 64'd0);
                tx_got.push_back(bus.dout);
                if (tx_got.size() == bp_trigger) bp_left = 10;
            end
            @(posedge clk);
            #1;
            if (bp_left > 0) begin
                bus.tx_fifo_full = 1'b1;
                bp_left--;
            end else begin
                bus.tx_fifo_full = rand_bp && ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic push_header(input logic [7:0] cmd, input int addr, input int n_words);
        logic [15:0] a;
        a = 16'(addr);
        rx_q.push_back(cmd);
        rx_q.push_back(a[15:8]);
        rx_q.push_back(a[7:0]);
        rx_q.push_back(8'(n_words - 1));
    endtask

    task automatic send_write(input int addr);
        push_header(8'h31, addr, wq.size());
        foreach (wq[i]) begin
            for (int b = 3; b >= 0; b--) rx_q.push_back(wq[i][b*8 +: 8]);
            ref_mem[(addr + i) % DEPTH] = wq[i];
        end
    endtask

    task automatic send_read(input int addr, input int n_words);
        logic [31:0] w;
        push_header(8'h30, addr, n_words);
        for (int i = 0; i < n_words; i++) begin
            w = ref_mem[(addr + i) % DEPTH];
            for (int b = 3; b >= 0; b--) tx_exp.push_back(w[b*8 +: 8]);
        end
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (c < budget && !(rx_q.size() == 0 && bus.rx_fifo_empty === 1'b1 &&
                               bus.state_leds[2:0] == 3'd0 && tx_got.size() >= tx_exp.size())) begin
            @(negedge clk);
            c++;
        end
        check_eq("done_within_budget", 64'(c >= budget), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_tx(input string tag);
        int n;
        check_eq({tag, "_count"}, 64'(tx_got.size()), 64'(tx_exp.size()));
        n = (tx_got.size() < tx_exp.size()) ? tx_got.size() : tx_exp.size();
        for (int i = 0; i < n; i++) check_eq({tag, "_byte"}, 64'(tx_got[i]), 64'(tx_exp[i]));
        tx_got.delete();
        tx_exp.delete();
    endtask

    task automatic check_quiet_outputs(input string tag);
        check_eq({tag, "_rd_en"}, 64'(bus.rx_fifo_rd_en), 64'd0);
        check_eq({tag, "_wr_en"}, 64'(bus.tx_fifo_wr_en), 64'd0);
        check_eq({tag, "_dout"},  64'(bus.dout),          64'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int a;
        int n;
        bus.rx_fifo_empty = 1'b1;
        bus.tx_fifo_full  = 1'b0;
        bus.din           = '0;
        rst               = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet_outputs("reset_cycle");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_quiet_outputs("after_reset");
        check_eq("reset_leds", 64'(bus.state_leds), 64'd0);

        // Single write then read
        wq = {32'hDEADBEEF};
        send_write(5);
        send_read(5, 1);
        wait_done(5000);
        compare_tx("single_rw");
        check_eq("single_mem5", 64'(dut.mem[5]), 64'h0000_0000_DEAD_BEEF);

        // Burst across the top of memory, then read it back under a 10-cycle full window
        wq = {32'h00010203, 32'h04050607, 32'h08090A0B};
        send_write(16'h03FF);
        wait_done(5000);
        check_eq("wrap_mem3ff", 64'(dut.mem[10'h3FF]), 64'h00010203);
        check_eq("wrap_mem000", 64'(dut.mem[10'h000]), 64'h04050607);
        check_eq("wrap_mem001", 64'(dut.mem[10'h001]), 64'h08090A0B);
        bp_trigger = 2;
        send_read(16'h03FF, 3);
        wait_done(5000);
        bp_trigger = -1;
        compare_tx("wrap_bp_read");

        // RX starvation: overwrite word 5, then rewrite DEADBEEF with random empty gaps
        wq = {32'h12345678};
        send_write(5);
        wait_done(5000);
        starve_max = 20;
        wq = {32'hDEADBEEF};
        send_write(5);
        wait_done(10000);
        starve_max = 0;
        check_eq("starve_mem5", 64'(dut.mem[5]), 64'hDEADBEEF);
        check_eq("bad_flag_clear", 64'(bus.state_leds[5]), 64'd0);

        // Bad command is dropped without touching memory or TX
        rx_q.push_back(8'h7A);
        wait_done(2000);
        check_eq("bad_flag_set", 64'(bus.state_leds[5]), 64'd1);
        check_eq("bad_state_idle", 64'(bus.state_leds[2:0]), 64'd0);
        check_eq("bad_no_tx", 64'(tx_got.size()), 64'd0);
        send_read(5, 1);
        wait_done(5000);
        compare_tx("after_bad_read");
        check_eq("bad_flag_sticky", 64'(bus.state_leds[5]), 64'd1);

        // Reset after 6 data bytes of a 3-word write
        wq = {32'h11111111, 32'h22222222, 32'h33333333};
        send_write(16'h0010);
        wait_done(5000);
        push_header(8'h31, 16'h0010, 3);
        rx_q.push_back(8'hAA); rx_q.push_back(8'hAB); rx_q.push_back(8'hAC); rx_q.push_back(8'hAD);
        rx_q.push_back(8'hB0); rx_q.push_back(8'hB1);
        ref_mem[16'h0010] = 32'hAAABACAD;
        for (int i = 0; i < 200 && rx_q.size() > 0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        check_eq("midburst_write_leds", 64'(bus.state_leds[4:0]), 64'h0C);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_quiet_outputs("midburst_reset_cycle");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_quiet_outputs("midburst_after_reset");
        check_eq("midburst_leds", 64'(bus.state_leds), 64'd0);
        check_eq("midburst_mem010", 64'(dut.mem[10'h010]), 64'hAAABACAD);
        check_eq("midburst_mem011", 64'(dut.mem[10'h011]), 64'h22222222);
        check_eq("midburst_mem012", 64'(dut.mem[10'h012]), 64'h33333333);
        send_read(16'h0010, 3);
        wait_done(5000);
        compare_tx("after_reset_read");

        // Randomised write/read bursts with random RX gaps and TX backpressure
        rand_bp = 1'b1;
        for (int t = 0; t < 12; t++) begin
            a = $urandom_range(0, DEPTH - 1);
            n = $urandom_range(1, 6);
            starve_max = ($urandom_range(0, 1) == 1) ? 5 : 0;
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            send_write(a);
            send_read(a, n);
            wait_done(10000);
            compare_tx("rand_burst");
            check_eq("rand_mem_first", 64'(dut.mem[a]), 64'(ref_mem[a]));
        end
        starve_max = 0;

        // Maximum length burst (LEN=0xFF) wrapping past the end of memory
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back($urandom);
        send_write(16'h0380);
        send_read(16'h0380, 256);
        wait_done(20000);
        compare_tx("max_burst");
        check_eq("max_mem_wrap", 64'(dut.mem[10'h07F]), 64'(ref_mem[10'h07F]));
        rand_bp = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
